ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
Memory stage of the 5-stage MIPS pipeline, directly downstream of the execute stage. Holds the EX/MEM register and a word-addressed data memory with synchronous read, and builds the MEM/WB register. Produces the forwarding selects and data (memAdelant/wbAdelant) that the execute stage consumes. Also resolves branches taken in MEM.

Parameters:
DATA_W, 32, datapath width
ADDR_W, 6, data-memory word-address width (2^ADDR_W words)
PC_W, 5, branch-target width (matches the execute-stage adder output)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
ex_alu_result  in  DATA_W  ALU result from execute
ex_store_data  in  DATA_W  forwarded rt value for stores
ex_wreg  in  5  destination register (RegDst mux output)
ex_zero  in  1  zero flag from execute
ex_branch_target  in  PC_W  PC + (imm<<2) from execute
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  in  1 each  control bits
ex_rs, ex_rt  in  5 each  source register numbers of the instruction currently in execute
hold  in  1  freeze stage (stall)
flush  in  1  turn incoming instruction into a bubble
mem_fwd_rs, mem_fwd_rt  out  1 each  forward from EX/MEM
wb_fwd_rs, wb_fwd_rt  out  1 each  forward from MEM/WB
mem_fwd_data  out  DATA_W  EX/MEM ALU result
wb_data  out  DATA_W  MEM/WB write-back value
wb_reg  out  5  write-back register number
wb_reg_write  out  1  write-back enable
load_use_hazard  out  1  stall request to hazard logic
pc_src  out  1  branch taken
branch_target  out  PC_W  registered branch target
mem_fault  out  1  see Optional Feature

Behaviour:
- Reset (async, reset_n=0): all EX/MEM and MEM/WB registers go to 0. All outputs read 0. Memory contents are not reset.
- Edge N+1: EX/MEM captures ex_* when hold=0.
  - flush=1: control bits (reg_write, mem_read, mem_write, mem_to_reg, branch) are captured as 0; data fields are captured normally.
  - flush overrides hold: bubble inserted even while held.
- Address = exm_alu_result[ADDR_W+1:2]. Low 2 bits are ignored. Upper bits are ignored (wrap-around).
- Edge N+2, unless hold=1:
  - Store: if exm_mem_write, mem[addr] <= exm_store_data.
  - Load: mem[addr] is read synchronously.
  - MEM/WB captures wb_data = exm_mem_to_reg ? mem[addr] (old contents) : exm_alu_result, plus wb_reg and wb_reg_write.
  - Load-to-WB latency is 2 cycles from EX.
- hold=1: both registers retain their values, memory writes are suppressed, and outputs are stable.
- pc_src = exm_branch & exm_zero (combinational from EX/MEM). branch_target = exm_branch_target.
- Forwarding (combinational, rs shown; rt identical):
  - mem_fwd_rs = exm_reg_write & ~exm_mem_to_reg & (exm_wreg!=0) & (exm_wreg==ex_rs).
  - wb_fwd_rs = wb_reg_write & (wb_reg!=0) & (wb_reg==ex_rs) & ~(exm_reg_write & exm_wreg==ex_rs & exm_wreg!=0).
  - EX/MEM has priority over MEM/WB.
- load_use_hazard = exm_mem_to_reg & exm_reg_write & (exm_wreg!=0) & (exm_wreg==ex_rs | exm_wreg==ex_rt).
- Register 0 never forwards and never raises a hazard.
- Reset asserted mid-store: the write is dropped and the pipeline is cleared immediately.

Optional Feature:
EXMEM_BOUNDS_CHECK_EN
- Defined: an access (mem_read or mem_write) with any exm_alu_result bit above ADDR_W+1 set is out of range.
  - The write is suppressed and the load returns 0.
  - mem_fault is set sticky on that edge and cleared only by reset_n.
- Undefined: addresses wrap and mem_fault is tied 0.

Test Plan:
- Reset: drive reset_n=0 mid-run -> all outputs 0 asynchronously; after release, wb_reg_write=0 until the first valid instruction reaches MEM/WB.
- Store/load: sw of 0xDEADBEEF at addr 0x10, then lw $5 from 0x10 -> two cycles after the lw leaves EX, wb_data=0xDEADBEEF, wb_reg=5, wb_reg_write=1.
- Forwarding: add $3 in EX/MEM while the EX instruction has rs=3 -> mem_fwd_rs=1, mem_fwd_data=ALU sum. Same $3 in MEM/WB and EX/MEM -> mem_fwd_rs=1, wb_fwd_rs=0. Writing $0 -> no forward.
- Load-use: lw $7 in EX/MEM while ex_rt=7 -> load_use_hazard=1, mem_fwd_rt=0. Next cycle (value in MEM/WB) -> wb_fwd_rt=1.
- Hold/flush: hold=1 for 3 cycles with a pending sw -> memory unchanged, outputs stable. flush=1 together with hold=1 -> EX/MEM control bits 0, no write.
- Branch: ex_branch=1, ex_zero=1, target=5'h14 -> pc_src=1, branch_target=5'h14 one edge later. With ex_zero=0 -> pc_src=0.
- Bounds (macro on): lw at 0x400 with ADDR_W=6 -> wb_data=0, mem_fault=1 until reset.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: MIPS memory stage (EX/MEM + MEM/WB registers, data memory, forwarding, branch resolve); define EXMEM_BOUNDS_CHECK_EN for out-of-range access faulting
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int PC_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [4:0]        ex_wreg,
    input  logic              ex_zero,
    input  logic [PC_W-1:0]   ex_branch_target,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_branch,
    input  logic [4:0]        ex_rs,
    input  logic [4:0]        ex_rt,
    input  logic              hold,
    input  logic              flush,
    output logic              mem_fwd_rs,
    output logic              mem_fwd_rt,
    output logic              wb_fwd_rs,
    output logic              wb_fwd_rt,
    output logic [DATA_W-1:0] mem_fwd_data,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_reg,
    output logic              wb_reg_write,
    output logic              load_use_hazard,
    output logic              pc_src,
    output logic [PC_W-1:0]   branch_target,
    output logic              mem_fault
);
    logic [DATA_W-1:0] exm_alu_q, exm_alu_d, exm_store_q, exm_store_d;
    logic [4:0]        exm_wreg_q, exm_wreg_d;
    logic [4:0]        exm_ctrl_q, exm_ctrl_d;
    logic              exm_zero_q, exm_zero_d;
    logic [PC_W-1:0]   exm_bt_q, exm_bt_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [4:0]        wb_reg_q, wb_reg_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
    logic              exm_rw, exm_mr, exm_mw, exm_m2r, exm_br;
    logic              oob, we;
    logic              exm_hit_rs, exm_hit_rt, wb_hit_rs, wb_hit_rt;

    assign {exm_rw, exm_mr, exm_mw, exm_m2r, exm_br} = exm_ctrl_q;
    assign addr  = exm_alu_q[ADDR_W+1:2];
    assign rdata = (exm_mr & ~oob) ? mem[addr] : '0;
    assign we    = exm_mw & ~hold & ~oob;

`ifdef EXMEM_BOUNDS_CHECK_EN
    logic fault_q, fault_d;

    assign oob       = (exm_mr | exm_mw) & |exm_alu_q[DATA_W-1:ADDR_W+2];
    assign mem_fault = fault_q;

    // fault is sticky once an out-of-range access retires
    always_comb begin
        fault_d = fault_q | (oob & ~hold);
    end

    // fault flag register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fault_q <= 1'b0;
        else          fault_q <= fault_d;
    end
`else
    assign oob       = 1'b0;
    assign mem_fault = 1'b0;
`endif

    // next-state: hold freezes both stages, flush bubbles EX/MEM control even while held
    always_comb begin
        exm_ctrl_d     = flush ? 5'd0 : hold ? exm_ctrl_q :
                         {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch};
        exm_alu_d      = hold ? exm_alu_q   : ex_alu_result;
        exm_store_d    = hold ? exm_store_q : ex_store_data;
        exm_wreg_d     = hold ? exm_wreg_q  : ex_wreg;
        exm_zero_d     = hold ? exm_zero_q  : ex_zero;
        exm_bt_d       = hold ? exm_bt_q    : ex_branch_target;
        wb_data_d      = hold ? wb_data_q   : exm_m2r ? rdata : exm_alu_q;
        wb_reg_d       = hold ? wb_reg_q    : exm_wreg_q;
        wb_reg_write_d = hold ? wb_reg_write_q : exm_rw;
    end

    // EX/MEM and MEM/WB pipeline registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exm_ctrl_q     <= '0;
            exm_alu_q      <= '0;
            exm_store_q    <= '0;
            exm_wreg_q     <= '0;
            exm_zero_q     <= 1'b0;
            exm_bt_q       <= '0;
            wb_data_q      <= '0;
            wb_reg_q       <= '0;
            wb_reg_write_q <= 1'b0;
        end else begin
            exm_ctrl_q     <= exm_ctrl_d;
            exm_alu_q      <= exm_alu_d;
            exm_store_q    <= exm_store_d;
            exm_wreg_q     <= exm_wreg_d;
            exm_zero_q     <= exm_zero_d;
            exm_bt_q       <= exm_bt_d;
            wb_data_q      <= wb_data_d;
            wb_reg_q       <= wb_reg_d;
            wb_reg_write_q <= wb_reg_write_d;
        end
    end

    // data memory write port; contents survive reset but a store under reset is dropped
    always_ff @(posedge clk) begin
        if (reset_n && we) mem[addr] <= exm_store_q;
    end

    assign exm_hit_rs = exm_rw & (exm_wreg_q != 5'd0) & (exm_wreg_q == ex_rs);
    assign exm_hit_rt = exm_rw & (exm_wreg_q != 5'd0) & (exm_wreg_q == ex_rt);
    assign wb_hit_rs  = wb_reg_write_q & (wb_reg_q != 5'd0) & (wb_reg_q == ex_rs);
    assign wb_hit_rt  = wb_reg_write_q & (wb_reg_q != 5'd0) & (wb_reg_q == ex_rt);

    assign mem_fwd_rs      = exm_hit_rs & ~exm_m2r;
    assign mem_fwd_rt      = exm_hit_rt & ~exm_m2r;
    assign wb_fwd_rs       = wb_hit_rs & ~exm_hit_rs;
    assign wb_fwd_rt       = wb_hit_rt & ~exm_hit_rt;
    assign load_use_hazard = exm_m2r & (exm_hit_rs | exm_hit_rt);
    assign mem_fwd_data    = exm_alu_q;
    assign wb_data         = wb_data_q;
    assign wb_reg          = wb_reg_q;
    assign wb_reg_write    = wb_reg_write_q;
    assign pc_src          = exm_br & exm_zero_q;
    assign branch_target   = exm_bt_q;
endmodule
